// File: rtl/muldiv_unit_if.sv
// Bus bundle for the iterative multiply/divide unit.
//   master : pipeline side - launches ops, writes HI/LO (MTHI/MTLO), flags a pending MFHI/MFLO.
//   slave  : muldiv_unit   - returns HI/LO, busy, done pulse, divide-by-zero flag and the stall.
// Signals:
//   start, op[1:0], os, ot      operation launch (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   wr_hi, wr_lo, w_data        MTHI/MTLO writes (honoured only while idle)
//   rd_hilo                     an MFHI/MFLO sits in the HI/LO read stage
//   hi, lo                      architectural HI/LO registers
//   busy, done, div_by_zero     status
//   stall                       busy & rd_hilo
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] os;
    logic [WIDTH-1:0] ot;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] w_data;
    logic             rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;

    modport master (
        output start, op, os, ot, wr_hi, wr_lo, w_data, rd_hilo,
        input  hi, lo, busy, done, div_by_zero, stall
    );

    modport slave (
        input  start, op, os, ot, wr_hi, wr_lo, w_data, rd_hilo,
        output hi, lo, busy, done, div_by_zero, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One iteration per cycle: start edge -> WIDTH RUN edges -> FIN edge writes HI/LO and pulses done.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    muldiv_unit_if.slave (operands, MTHI/MTLO, HI/LO, busy/done/div_by_zero/stall)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    // Shared accumulator: multiply = {partial product, remaining multiplier},
    // divide = {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b;          // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   dividend;   // raw os, returned in HI on divide by zero
    logic               is_div, neg_res, neg_rem, dz;
    logic [WIDTH-1:0]   hi, lo;
    logic               done, dbz;
    logic               busy;

    // Operand capture: signed ops work on magnitudes and fix signs at FIN.
    logic               signed_op, os_neg, ot_neg;
    logic [WIDTH-1:0]   os_mag, ot_mag;

    always_comb begin
        signed_op = ~bus.op[0];
        os_neg    = signed_op & bus.os[WIDTH-1];
        ot_neg    = signed_op & bus.ot[WIDTH-1];
        os_mag    = os_neg ? -bus.os : bus.os;
        ot_mag    = ot_neg ? -bus.ot : bus.ot;
    end

    // One iteration of each algorithm.
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // Restoring step: trial subtract of the divisor from {rem, next dividend bit};
        // a set top bit means the subtraction borrowed, so keep the shifted remainder.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b};
        div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Final sign correction / divide-by-zero result.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (dz) begin
                lo_res = '1;
                hi_res = dividend;
            end else begin
                lo_res = quo;
                hi_res = rem;
            end
        end else begin
            lo_res = prod[WIDTH-1:0];
            hi_res = prod[2*WIDTH-1:WIDTH];
        end
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (count == LAST) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and architectural registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            b        <= '0;
            dividend <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_hi) hi <= bus.w_data;
                    if (bus.wr_lo) lo <= bus.w_data;
                    if (bus.start) begin
                        acc      <= {{WIDTH{1'b0}}, os_mag};
                        b        <= ot_mag;
                        dividend <= bus.os;
                        is_div   <= bus.op[1];
                        neg_res  <= os_neg ^ ot_neg;
                        neg_rem  <= os_neg;
                        dz       <= (bus.ot == '0);
                        count    <= '0;
                        dbz      <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FIN: begin
                    hi   <= hi_res;
                    lo   <= lo_res;
                    done <= 1'b1;
                    dbz  <= is_div & dz;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state != IDLE);
    assign bus.busy        = busy;
    assign bus.stall       = busy & bus.rd_hilo;
    assign bus.hi          = hi;
    assign bus.lo          = lo;
    assign bus.done        = done;
    assign bus.div_by_zero = dbz;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the source-operand forwarding stage. It consumes the forwarded rs/rt operands and runs MULT, MULTU, DIV and DIVU over multiple cycles, one iteration per cycle. Results go into internal HI/LO registers. While the unit is busy, it raises a pipeline stall whenever a HI/LO read (MFHI/MFLO) is pending.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits wide.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  launch the operation in op using os/ot; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
os  input  WIDTH  forwarded rs operand (multiplicand / dividend)
ot  input  WIDTH  forwarded rt operand (multiplier / divisor)
wr_hi  input  1  MTHI write enable
wr_lo  input  1  MTLO write enable
w_data  input  WIDTH  data for MTHI/MTLO
rd_hilo  input  1  an MFHI/MFLO is in the stage that reads HI/LO
hi  output  WIDTH  HI register (remainder / upper product)
lo  output  WIDTH  LO register (quotient / lower product)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when hi/lo have just been updated by an operation
div_by_zero  output  1  registered flag for the last completed divide; cleared by the next start
stall  output  1  busy & rd_hilo (combinational)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state returns to IDLE; iteration counter cleared.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Reset mid-operation abandons the operation; no partial result reaches hi/lo.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> RUN while count<WIDTH-1; RUN -> FIN at count==WIDTH-1.
  - FIN -> IDLE unconditionally.
- busy is registered; it is 1 exactly when state != IDLE.
- Latency: start sampled at edge E0; RUN occupies edges E1..E32; the FIN edge E33 writes hi/lo and sets done=1.
  - done is high for the one cycle after E33; busy is 0 in that same cycle.
  - A new start in that cycle is accepted.
- start while busy: ignored; no queueing.
- Capture at start:
  - Signed ops store operand magnitudes plus a sign flag for the result and a sign flag for the remainder.
  - Unsigned ops store the operands unchanged.
- Multiply: shift-add, one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator.
  - FIN negates the 64-bit product (two's complement) if the operand signs differ.
  - hi=product[63:32], lo=product[31:0].
- Divide: restoring, one quotient bit per RUN cycle.
  - FIN negates the quotient if the operand signs differ.
  - FIN negates the remainder if the dividend was negative.
  - lo=quotient, hi=remainder.
  - Signed overflow (0x80000000 / 0xFFFFFFFF) yields lo=0x80000000, hi=0 with no special case.
- Divide by zero (ot==0 at start, DIV or DIVU):
  - The full 33-cycle latency is kept.
  - Result lo=0xFFFFFFFF, hi=dividend as presented (os).
  - div_by_zero=1 from the FIN edge.
- wr_hi/wr_lo:
  - In IDLE, the selected register is written at the edge.
  - While busy (RUN or FIN), ignored.
  - Coinciding with start in IDLE, the write takes effect and is later overwritten by the operation result.
- rd_hilo while busy: stall=1 until the cycle in which done=1.
  - In that cycle stall=0 and the updated hi/lo are visible.
- Widths: all negation in two's complement within the stated width; no saturation.

Test Plan:
- Reset mid-op: MULTU start, reset asserted at RUN cycle 10 -> next cycle busy=0, hi=0, lo=0, done=0; no later done pulse.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done on the 34th cycle after the start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT signed -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV signed -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Hazard/contention: MTHI 0x1234 while busy -> ignored, hi equals the result. rd_hilo held high during the operation -> stall=1 every busy cycle and 0 in the done cycle. Second start in the done cycle -> accepted; busy=1 in the next cycle.
